// File: rtl/spi_host_regif_if.sv
// Host SPI pins plus the register-bank strobe bus of spi_host_regif.
// slave = the regif block itself, master = whatever drives the host pins / models the bank.
interface spi_host_regif_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  SCLK_fromHost;
  logic                  SCSN_fromHost;
  logic                  MOSI_fromHost;
  logic                  MISO_fromClient;
  logic                  MISO_toHost;
  logic [7:0]            RD_DATA;
  logic [ADDR_WIDTH-1:0] REG_ADDR;
  logic [7:0]            WR_DATA;
  logic                  WR_STROBE;
  logic                  RD_STROBE;

  modport slave (
    input  SCLK_fromHost, SCSN_fromHost, MOSI_fromHost, MISO_fromClient, RD_DATA,
    output MISO_toHost, REG_ADDR, WR_DATA, WR_STROBE, RD_STROBE
  );

  modport master (
    output SCLK_fromHost, SCSN_fromHost, MOSI_fromHost, MISO_fromClient, RD_DATA,
    input  MISO_toHost, REG_ADDR, WR_DATA, WR_STROBE, RD_STROBE
  );
endinterface

// File: rtl/spi_host_regif.sv
// SPI mode-0 register front end: oversamples host pins in the SPI_CLK domain and
// turns byte frames {RW,ADDR[6:0]}, data... into one-cycle register write/read strobes.
module spi_host_regif #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic            SPI_CLK,
  input  logic            SPI_CLK_RESET_N,
  spi_host_regif_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, scsn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, scsn_prev_q;
  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             mosi_sh_q, mosi_sh_d;
  logic [7:0]             miso_sh_q, miso_sh_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   wr_stb_q, wr_stb_d;
  logic                   rd_stb_q, rd_stb_d;
  logic                   load_q;

  logic       sclk_s, scsn_s, mosi_s;
  logic       sclk_rise, sclk_fall, scsn_fall, scsn_rise;
  logic       byte_done;
  logic [7:0] byte_val;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign scsn_s    = scsn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign scsn_fall = ~scsn_s & scsn_prev_q;
  assign scsn_rise = scsn_s & ~scsn_prev_q;
  assign byte_val  = {mosi_sh_q[6:0], mosi_s};

  // SCSN chain resets low so a reset released mid-frame cannot fake a select edge.
  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) begin
      sclk_sync_q <= '0;
      scsn_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      scsn_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mosi_sh_q   <= 8'd0;
      miso_sh_q   <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK_fromHost};
      scsn_sync_q <= {scsn_sync_q[SYNC_STAGES-2:0], bus.SCSN_fromHost};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI_fromHost};
      sclk_prev_q <= sclk_s;
      scsn_prev_q <= scsn_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mosi_sh_q   <= mosi_sh_d;
      miso_sh_q   <= miso_sh_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      load_q      <= rd_stb_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mosi_sh_d = mosi_sh_q;
    miso_sh_d = miso_sh_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    byte_done = 1'b0;

    if (wr_stb_q) begin
      addr_d = addr_q + ADDR_ONE;
    end

    // The fall that closes a byte (count already wrapped to 0) must not shift out the
    // freshly loaded MSB before the host samples it on the next rise.
    if (load_q) begin
      miso_sh_d = bus.RD_DATA;
    end else if (sclk_fall && cnt_q != 3'd0 && state_q != IDLE) begin
      miso_sh_d = {miso_sh_q[6:0], 1'b0};
    end

    if (state_q == IDLE) begin
      if (scsn_fall) begin
        state_d   = ADDR;
        cnt_d     = 3'd0;
        mosi_sh_d = 8'd0;
        miso_sh_d = 8'd0;
      end
    end else if (sclk_rise) begin
      cnt_d     = cnt_q + 3'd1;
      mosi_sh_d = byte_val;
      byte_done = (cnt_q == 3'd7);
    end

    if (byte_done) begin
      case (state_q)
        ADDR: begin
          addr_d = byte_val[ADDR_WIDTH-1:0];
          if (byte_val[7]) begin
            state_d = WDATA;
          end else begin
            state_d  = RDATA;
            rd_stb_d = 1'b1;
          end
        end
        WDATA: begin
          wdata_d  = byte_val;
          wr_stb_d = 1'b1;
        end
        RDATA: begin
          addr_d   = addr_q + ADDR_ONE;
          rd_stb_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Deselect drops any partial byte; a byte completing in the same cycle still strobes.
    if (state_q != IDLE && scsn_rise) begin
      state_d   = IDLE;
      cnt_d     = 3'd0;
      mosi_sh_d = 8'd0;
    end
  end

  assign bus.REG_ADDR    = addr_q;
  assign bus.WR_DATA     = wdata_q;
  assign bus.WR_STROBE   = wr_stb_q;
  assign bus.RD_STROBE   = rd_stb_q;
  assign bus.MISO_toHost = (!scsn_s && state_q != IDLE) ? miso_sh_q[7] : bus.MISO_fromClient;
endmodule

// File: tb/tb_spi_host_regif.sv
// Bench for spi_host_regif: bit-banged SPI host at SPI_CLK/8, register bank read model,
// directed vector table, hand-written abort/reset sequences and randomized frames.
module tb_spi_host_regif;
  logic SPI_CLK = 1'b0;
  logic SPI_CLK_RESET_N = 1'b0;

  spi_host_regif_if #(.ADDR_WIDTH(7)) bus ();

  spi_host_regif #(.SYNC_STAGES(2), .ADDR_WIDTH(7)) dut (
    .SPI_CLK        (SPI_CLK),
    .SPI_CLK_RESET_N(SPI_CLK_RESET_N),
    .bus            (bus)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  logic [7:0] mem [128];
  assign bus.RD_DATA = mem[bus.REG_ADDR];

  int tests = 0;
  int fails = 0;

  logic [6:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [6:0] rd_a [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe log, sampled mid-cycle; each strobe must be alone and one cycle wide.
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;
  always @(negedge SPI_CLK) begin
    if (bus.WR_STROBE) begin
      wr_a.push_back(bus.REG_ADDR);
      wr_d.push_back(bus.WR_DATA);
      check("wr_excl_rd", {31'd0, bus.RD_STROBE}, 32'd0);
      check("wr_width", {31'd0, wr_prev}, 32'd0);
    end
    if (bus.RD_STROBE) begin
      rd_a.push_back(bus.REG_ADDR);
      check("rd_width", {31'd0, rd_prev}, 32'd0);
    end
    wr_prev = bus.WR_STROBE;
    rd_prev = bus.RD_STROBE;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge SPI_CLK);
    #2;
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask

  task automatic host_bit(input logic b, output logic r);
    bus.MOSI_fromHost   = b;
    bus.MISO_fromClient = 1'($urandom_range(0, 1));
    tick(4);
    r = bus.MISO_toHost;
    bus.SCLK_fromHost = 1'b1;
    tick(4);
    bus.SCLK_fromHost = 1'b0;
  endtask

  task automatic host_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    rx = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      host_bit(tx[i], r);
      rx = {rx[6:0], r};
    end
  endtask

  task automatic run_frame(input logic [31:0] tx, input int nb, output logic [31:0] rx);
    logic [7:0] r;
    clear_logs();
    rx = 32'd0;
    bus.SCSN_fromHost = 1'b0;
    tick(4);
    for (int k = 0; k < nb; k++) begin
      host_byte(tx[31-8*k -: 8], r);
      rx[31-8*k -: 8] = r;
    end
    tick(4);
    bus.SCSN_fromHost = 1'b1;
    tick(10);
  endtask

  typedef struct {
    logic [31:0] tx;
    int          nb;
    bit          is_rd;
    int          n;         // expected strobe count (WR for writes, RD for reads)
    logic [6:0]  a0;
    logic [7:0]  d0;        // first write data, or first received byte for reads
    logic [6:0]  al;
    logic [7:0]  dl;
    logic [6:0]  end_addr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] rx;
    logic [7:0]  r8;
    logic        rb;
    logic [7:0]  d [3];

    bus.SCLK_fromHost   = 1'b0;
    bus.SCSN_fromHost   = 1'b1;
    bus.MOSI_fromHost   = 1'b0;
    bus.MISO_fromClient = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[7'h12] = 8'hA7;
    mem[7'h13] = 8'h5A;
    mem[7'h7F] = 8'hC3;
    mem[7'h00] = 8'h3E;

    vecs[0] = '{32'h853C_0000, 2, 1'b0, 1, 7'h05, 8'h3C, 7'h05, 8'h3C, 7'h06};
    vecs[1] = '{32'h1200_0000, 2, 1'b1, 2, 7'h12, 8'hA7, 7'h13, 8'hA7, 7'h13};
    vecs[2] = '{32'hFE11_2233, 4, 1'b0, 3, 7'h7E, 8'h11, 7'h00, 8'h33, 7'h01};
    vecs[3] = '{32'h7F00_0000, 3, 1'b1, 3, 7'h7F, 8'hC3, 7'h01, 8'h3E, 7'h01};
    vecs[4] = '{32'h8166_0000, 2, 1'b0, 1, 7'h01, 8'h66, 7'h01, 8'h66, 7'h02};
    vecs[5] = '{32'h9000_0000, 1, 1'b0, 0, 7'h00, 8'h00, 7'h00, 8'h00, 7'h10};

    // Reset state and deselected passthrough
    tick(5);
    check("rst_addr", {25'd0, bus.REG_ADDR}, 32'd0);
    check("rst_wdata", {24'd0, bus.WR_DATA}, 32'd0);
    check("rst_strobes", {30'd0, bus.WR_STROBE, bus.RD_STROBE}, 32'd0);
    SPI_CLK_RESET_N = 1'b1;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      rb = 1'((i == 1) || (i == 2));
      bus.MISO_fromClient = rb;
      #1;
      check("passthru", {31'd0, bus.MISO_toHost}, {31'd0, rb});
    end

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].tx, vecs[i].nb, rx);
      if (vecs[i].is_rd) begin
        check($sformatf("v%0d_rd_cnt", i), rd_a.size(), vecs[i].n);
        check($sformatf("v%0d_wr_cnt", i), wr_a.size(), 0);
        if (rd_a.size() > 0) begin
          check($sformatf("v%0d_rd_a0", i), {25'd0, rd_a[0]}, {25'd0, vecs[i].a0});
          check($sformatf("v%0d_rd_al", i), {25'd0, rd_a[rd_a.size()-1]}, {25'd0, vecs[i].al});
        end
        check($sformatf("v%0d_rx0", i), {24'd0, rx[23:16]}, {24'd0, vecs[i].d0});
        check($sformatf("v%0d_rxl", i), {24'd0, rx[31-8*(vecs[i].nb-1) -: 8]}, {24'd0, vecs[i].dl});
      end else begin
        check($sformatf("v%0d_wr_cnt", i), wr_a.size(), vecs[i].n);
        check($sformatf("v%0d_rd_cnt", i), rd_a.size(), 0);
        if (wr_a.size() > 0 && vecs[i].n > 0) begin
          check($sformatf("v%0d_wr_a0", i), {25'd0, wr_a[0]}, {25'd0, vecs[i].a0});
          check($sformatf("v%0d_wr_d0", i), {24'd0, wr_d[0]}, {24'd0, vecs[i].d0});
          check($sformatf("v%0d_wr_al", i), {25'd0, wr_a[wr_a.size()-1]}, {25'd0, vecs[i].al});
          check($sformatf("v%0d_wr_dl", i), {24'd0, wr_d[wr_d.size()-1]}, {24'd0, vecs[i].dl});
        end
      end
      check($sformatf("v%0d_end_addr", i), {25'd0, bus.REG_ADDR}, {25'd0, vecs[i].end_addr});
    end

    // Abort: write command, 5 data bits, deselect
    clear_logs();
    bus.SCSN_fromHost = 1'b0;
    tick(4);
    host_byte(8'h85, r8);
    for (int i = 0; i < 5; i++) host_bit(1'b1, rb);
    tick(4);
    bus.SCSN_fromHost = 1'b1;
    tick(10);
    check("abort_no_wr", wr_a.size(), 0);
    check("abort_addr_hold", {25'd0, bus.REG_ADDR}, 32'h05);
    check("abort_wdata_hold", {24'd0, bus.WR_DATA}, 32'h66);
    run_frame(32'h8155_0000, 2, rx);
    check("post_abort_cnt", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      check("post_abort_a", {25'd0, wr_a[0]}, 32'h01);
      check("post_abort_d", {24'd0, wr_d[0]}, 32'h55);
    end

    // Reset after 10 bits of a write burst
    clear_logs();
    bus.SCSN_fromHost = 1'b0;
    tick(4);
    host_byte(8'h83, r8);
    host_bit(1'b0, rb);
    host_bit(1'b1, rb);
    tick(1);
    SPI_CLK_RESET_N = 1'b0;
    bus.MISO_fromClient = 1'b1;
    #1;
    check("mrst_addr", {25'd0, bus.REG_ADDR}, 32'd0);
    check("mrst_wdata", {24'd0, bus.WR_DATA}, 32'd0);
    check("mrst_miso", {31'd0, bus.MISO_toHost}, 32'd1);
    tick(3);
    SPI_CLK_RESET_N = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) host_bit(1'b0, rb);
    host_byte(8'h99, r8);
    tick(4);
    bus.SCSN_fromHost = 1'b1;
    tick(10);
    check("mrst_no_wr", wr_a.size(), 0);
    check("mrst_no_rd", rd_a.size(), 0);
    run_frame(32'h8ABE_0000, 2, rx);
    check("mrst_new_cnt", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      check("mrst_new_a", {25'd0, wr_a[0]}, 32'h0A);
      check("mrst_new_d", {24'd0, wr_d[0]}, 32'hBE);
    end

    // Randomized frames against an address-arithmetic reference model
    for (int f = 0; f < 24; f++) begin
      int         a, n;
      bit         is_wr;
      logic [31:0] tx;
      is_wr = 1'($urandom_range(0, 1));
      a     = int'($urandom_range(0, 127));
      n     = int'($urandom_range(1, 3));
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      tx = {is_wr, 7'(a), d[0], d[1], d[2]};
      if (!is_wr) begin
        for (int i = 0; i <= n; i++) mem[7'(a + i)] = 8'($urandom);
      end
      run_frame(tx, n + 1, rx);
      if (is_wr) begin
        check($sformatf("r%0d_wr_cnt", f), wr_a.size(), n);
        check($sformatf("r%0d_rd_cnt", f), rd_a.size(), 0);
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
          check($sformatf("r%0d_wa%0d", f, i), {25'd0, wr_a[i]}, {25'd0, 7'(a + i)});
          check($sformatf("r%0d_wd%0d", f, i), {24'd0, wr_d[i]}, {24'd0, d[i]});
        end
      end else begin
        check($sformatf("r%0d_rd_cnt", f), rd_a.size(), n + 1);
        check($sformatf("r%0d_wr_cnt", f), wr_a.size(), 0);
        for (int i = 0; i <= n && i < rd_a.size(); i++)
          check($sformatf("r%0d_ra%0d", f, i), {25'd0, rd_a[i]}, {25'd0, 7'(a + i)});
        for (int i = 0; i < n; i++)
          check($sformatf("r%0d_rx%0d", f, i), {24'd0, rx[23-8*i -: 8]}, {24'd0, mem[7'(a + i)]});
      end
      check($sformatf("r%0d_end_addr", f), {25'd0, bus.REG_ADDR}, {25'd0, 7'(a + n)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
